// File: rtl/ring_out_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ring_out_arbiter_pkg
//   Shared definitions for the ring output arbiter and its holding stage:
//   one-hot FSM state encoding, ring packet counter width and saturation
//   value, source-select encodings for cur_src, and the field layout of a
//   packed ring word (PRW) as stored in the output holding register.
// ----------------------------------------------------------------------------
package ring_out_arbiter_pkg;

    // Number of sources feeding the ring output (ring pass-through, local).
    localparam int NUM_PORTS = 2;

    // Consecutive ring packet counter.
    localparam int                    RING_CNT_W   = 4;
    localparam logic [RING_CNT_W-1:0] RING_CNT_MAX = 4'd15;

    // Packed ring word layout inside the holding stage: eop in bit 0,
    // datapath bits immediately above it.
    localparam int PRW_EOP      = 0;
    localparam int PRW_DATA_LSB = 1;

    // cur_src encodings (one-hot owner, all-zero when nobody owns the output).
    localparam logic [NUM_PORTS-1:0] SRC_NONE  = 2'b00;
    localparam logic [NUM_PORTS-1:0] SRC_RING  = 2'b01;
    localparam logic [NUM_PORTS-1:0] SRC_LOCAL = 2'b10;

    // Arbiter FSM, one-hot.
    typedef enum logic [2:0] {
        s_idle  = 3'b001,
        s_ring  = 3'b010,
        s_local = 3'b100
    } arb_state_e;

    // Saturating increment of the ring packet counter.
    function automatic logic [RING_CNT_W-1:0] ring_cnt_inc(input logic [RING_CNT_W-1:0] v);
        if (v == RING_CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/ring_out_hold_reg.sv
// ----------------------------------------------------------------------------
// ring_out_hold_reg
//   Single-entry registered holding stage with srdy/drdy on both sides.
//   Output data and valid come straight from flops. The stage accepts a new
//   word whenever it is empty or its current word is being drained in the
//   same cycle, so it sustains one word per cycle.
//
//   Ports:
//     clk        - clock, rising edge
//     reset      - asynchronous active-low reset, clears valid and data
//     in_srdy_i  - upstream word valid
//     in_drdy_o  - stage can take a word this cycle
//     in_data_i  - upstream word (width bits)
//     out_srdy_o - stage holds a valid word
//     out_drdy_i - downstream takes the held word this cycle
//     out_data_o - held word
// ----------------------------------------------------------------------------
module ring_out_hold_reg #(
    parameter int width = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_srdy_i,
    output logic             in_drdy_o,
    input  logic [width-1:0] in_data_i,
    output logic             out_srdy_o,
    input  logic             out_drdy_i,
    output logic [width-1:0] out_data_o
);

    logic             full_q;
    logic [width-1:0] data_q;
    logic             load;

    // Empty, or emptying this cycle.
    assign in_drdy_o  = ~full_q | out_drdy_i;
    assign load       = in_srdy_i & in_drdy_o;
    assign out_srdy_o = full_q;
    assign out_data_o = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (load) begin
                full_q <= 1'b1;
                data_q <= in_data_i;
            end else if (out_drdy_i) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ring_out_arbiter.sv
// ----------------------------------------------------------------------------
// ring_out_arbiter
//   Merges ring pass-through packets and locally injected packets onto the
//   ring output. Packets are never interleaved: once a source is granted it
//   keeps the output until its eop word transfers. Ring traffic is preferred,
//   but after max_ring_pkts consecutive ring packets a waiting local packet is
//   forced in; a local packet always clears that count, so a waiting ring
//   packet wins the arbitration right after it.
//
//   Handshake (all three interfaces): a word moves in a cycle where srdy and
//   drdy are both 1. srdy may not depend on drdy. drdy here depends only on
//   FSM state, the srdy inputs and the holding stage, never on data.
//
//   Ports:
//     clk                         - clock, rising edge
//     reset                       - asynchronous active-low reset
//     rin_srdy/drdy/data/eop      - ring pass-through words from the tap
//     lin_srdy/drdy/data/eop      - local injection words
//     lro_srdy/drdy/data/eop      - ring output, driven from flops
//     cur_src                     - one-hot output owner (bit0 ring, bit1 local)
// ----------------------------------------------------------------------------
module ring_out_arbiter
    import ring_out_arbiter_pkg::*;
#(
    parameter int rdp_sz        = 64,
    parameter int max_ring_pkts = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rin_srdy,
    output logic                 rin_drdy,
    input  logic [rdp_sz-1:0]    rin_data,
    input  logic                 rin_eop,
    input  logic                 lin_srdy,
    output logic                 lin_drdy,
    input  logic [rdp_sz-1:0]    lin_data,
    input  logic                 lin_eop,
    output logic                 lro_srdy,
    input  logic                 lro_drdy,
    output logic [rdp_sz-1:0]    lro_data,
    output logic                 lro_eop,
    output logic [NUM_PORTS-1:0] cur_src
);

    localparam int                    HOLD_W   = rdp_sz + 1;
    localparam logic [RING_CNT_W-1:0] MAX_RING = RING_CNT_W'(max_ring_pkts);

    arb_state_e              state_q, state_d;
    logic [RING_CNT_W-1:0]   ring_cnt_q, ring_cnt_d;

    logic                    hold_in_srdy;
    logic                    hold_in_drdy;
    logic [HOLD_W-1:0]       hold_in_data;
    logic [HOLD_W-1:0]       hold_out_data;
    logic                    hold_ok;

    logic                    pick_local;
    logic                    grant_ring;
    logic                    grant_local;
    logic                    rin_xfer;
    logic                    lin_xfer;

    // While reset is held the holding stage reads as empty; keep both drdy
    // low anyway so nothing is accepted until reset is released.
    assign hold_ok = reset & hold_in_drdy;

    // ------------------------------------------------------------------
    // Grant selection. In s_idle the new owner is chosen from the srdy
    // inputs and its first word moves in the same cycle. Local wins when the
    // ring has used up its run of packets or the ring has nothing to send.
    // ------------------------------------------------------------------
    always_comb begin
        pick_local  = lin_srdy & ((ring_cnt_q >= MAX_RING) | ~rin_srdy);
        grant_ring  = (state_q == s_ring)
                    | ((state_q == s_idle) & rin_srdy & ~pick_local);
        grant_local = (state_q == s_local)
                    | ((state_q == s_idle) & pick_local);
    end

    assign rin_drdy = grant_ring  & hold_ok;
    assign lin_drdy = grant_local & hold_ok;
    assign rin_xfer = rin_srdy & rin_drdy;
    assign lin_xfer = lin_srdy & lin_drdy;

    // ------------------------------------------------------------------
    // Data path into the holding stage.
    // ------------------------------------------------------------------
    always_comb begin
        hold_in_srdy = (grant_ring & rin_srdy) | (grant_local & lin_srdy);
        hold_in_data = '0;
        if (grant_local) begin
            hold_in_data[PRW_EOP]                  = lin_eop;
            hold_in_data[PRW_DATA_LSB +: rdp_sz]   = lin_data;
        end else begin
            hold_in_data[PRW_EOP]                  = rin_eop;
            hold_in_data[PRW_DATA_LSB +: rdp_sz]   = rin_data;
        end
    end

    ring_out_hold_reg #(
        .width (HOLD_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .in_srdy_i  (hold_in_srdy),
        .in_drdy_o  (hold_in_drdy),
        .in_data_i  (hold_in_data),
        .out_srdy_o (lro_srdy),
        .out_drdy_i (lro_drdy),
        .out_data_o (hold_out_data)
    );

    assign lro_data = hold_out_data[PRW_DATA_LSB +: rdp_sz];
    assign lro_eop  = hold_out_data[PRW_EOP];

    // ------------------------------------------------------------------
    // Owner indication. Inside a packet the state names the owner even on
    // bubble cycles; in s_idle it shows whichever source moves a word now.
    // ------------------------------------------------------------------
    always_comb begin
        cur_src = SRC_NONE;
        case (state_q)
            s_ring:  cur_src = SRC_RING;
            s_local: cur_src = SRC_LOCAL;
            default: begin
                if (rin_xfer) begin
                    cur_src = SRC_RING;
                end else if (lin_xfer) begin
                    cur_src = SRC_LOCAL;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next state. A single-word packet leaves the FSM in s_idle; a
    // multi-word packet locks the grant until its eop word moves.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;

        case (state_q)
            s_idle: begin
                if (rin_xfer && !rin_eop) begin
                    state_d = s_ring;
                end else if (lin_xfer && !lin_eop) begin
                    state_d = s_local;
                end
            end
            s_ring: begin
                if (rin_xfer && rin_eop) begin
                    state_d = s_idle;
                end
            end
            s_local: begin
                if (lin_xfer && lin_eop) begin
                    state_d = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase

        if (rin_xfer && rin_eop) begin
            ring_cnt_d = ring_cnt_inc(ring_cnt_q);
        end
        if (lin_xfer && lin_eop) begin
            ring_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= s_idle;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

endmodule

// File: tb/tb_ring_out_arbiter.sv
module tb_ring_out_arbiter;

    localparam int W    = 16;
    localparam int MAXR = 4;

    logic         clk;
    logic         reset;
    logic         rin_srdy, rin_drdy, rin_eop;
    logic [W-1:0] rin_data;
    logic         lin_srdy, lin_drdy, lin_eop;
    logic [W-1:0] lin_data;
    logic         lro_srdy, lro_drdy, lro_eop;
    logic [W-1:0] lro_data;
    logic [1:0]   cur_src;

    ring_out_arbiter #(
        .rdp_sz        (W),
        .max_ring_pkts (MAXR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rin_srdy (rin_srdy),
        .rin_drdy (rin_drdy),
        .rin_data (rin_data),
        .rin_eop  (rin_eop),
        .lin_srdy (lin_srdy),
        .lin_drdy (lin_drdy),
        .lin_data (lin_data),
        .lin_eop  (lin_eop),
        .lro_srdy (lro_srdy),
        .lro_drdy (lro_drdy),
        .lro_data (lro_data),
        .lro_eop  (lro_eop),
        .cur_src  (cur_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        rin_srdy = 0; rin_data = '0; rin_eop = 0;
        lin_srdy = 0; lin_data = '0; lin_eop = 0;
        lro_drdy = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " lro_srdy"}, lro_srdy, 0);
        check({tag, " lro_data"}, lro_data, 0);
        check({tag, " lro_eop"},  lro_eop,  0);
        check({tag, " cur_src"},  cur_src,  0);
        check({tag, " rin_drdy"}, rin_drdy, 0);
        check({tag, " lin_drdy"}, lin_drdy, 0);
    endtask

    // Called at a negedge, returns at a negedge with reset released.
    task automatic do_reset(input string tag);
        zero_inputs();
        reset = 0;
        #1;
        check_reset_outputs(tag);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rs; logic [W-1:0] rd; logic re;
        logic         ls; logic [W-1:0] ld; logic le;
        logic         od;
        logic         x_rdrdy; logic x_ldrdy; logic [1:0] x_src;
        logic         x_osrdy; logic [W-1:0] x_odata; logic x_oeop;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rs, input logic [W-1:0] rd, input logic re,
                           input logic ls, input logic [W-1:0] ld, input logic le,
                           input logic od, input logic xr, input logic xl,
                           input logic [1:0] xs, input logic xo,
                           input logic [W-1:0] xd, input logic xe);
        vec_t v;
        v.rs = rs; v.rd = rd; v.re = re;
        v.ls = ls; v.ld = ld; v.le = le;
        v.od = od;
        v.x_rdrdy = xr; v.x_ldrdy = xl; v.x_src = xs;
        v.x_osrdy = xo; v.x_odata = xd; v.x_oeop = xe;
        vecs.push_back(v);
    endtask

    // ---------------- driver / scoreboard for sequences ----------------
    logic [W:0] exp_q[$];   // {eop, data} expected on the output, in order
    logic [W:0] r_q[$];     // ring words still to offer
    logic [W:0] l_q[$];     // local words still to offer
    int r_start, l_start, l_stall_at, stall_left, l_sent;

    task automatic seq_setup();
        exp_q.delete(); r_q.delete(); l_q.delete();
        r_start = 0; l_start = 0; l_stall_at = -1; stall_left = 0; l_sent = 0;
    endtask

    // Called at a negedge, returns at a negedge.
    task automatic run_seq(input string tag, input int budget, input bit toggle,
                           input bit chk_no_lin, input int exp_bubbles);
        int   cyc     = 0;
        int   bubbles = 0;
        int   seen    = 0;
        bit   r_act   = 0;
        bit   l_act   = 0;
        bit   prev_in = 0;
        logic rx, lx;
        logic [1:0] exp_src;
        logic [W:0] w;
        while ((r_q.size() > 0 || l_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            rin_srdy = (cyc >= r_start) && (r_q.size() > 0);
            w = rin_srdy ? r_q[0] : '0;
            rin_eop = w[W]; rin_data = w[W-1:0];
            if (l_sent == l_stall_at && stall_left > 0) begin
                lin_srdy = 0;
                stall_left--;
            end else begin
                lin_srdy = (cyc >= l_start) && (l_q.size() > 0);
            end
            w = lin_srdy ? l_q[0] : '0;
            lin_eop = w[W]; lin_data = w[W-1:0];
            lro_drdy = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            rx = rin_srdy & rin_drdy;
            lx = lin_srdy & lin_drdy;
            check({tag, " drdy exclusive"}, rin_drdy & lin_drdy, 0);
            exp_src = l_act ? 2'b10 : (r_act ? 2'b01 : {lx, rx});
            check({tag, " cur_src"}, cur_src, exp_src);
            if (l_act) check({tag, " ring held off"}, rin_drdy, 0);
            if (chk_no_lin) check({tag, " lin_drdy"}, lin_drdy, 0);
            if (prev_in) check({tag, " latency"}, lro_srdy, 1);
            if (!lro_srdy && seen > 0 && exp_q.size() > 0) bubbles++;
            if (lro_srdy && lro_drdy) begin
                if (exp_q.size() == 0) begin
                    check({tag, " extra word"}, {lro_eop, lro_data}, 0);
                    n_fail += (n_fail == 0 && {lro_eop, lro_data} == 0) ? 1 : 0;
                end else begin
                    w = exp_q.pop_front();
                    check({tag, " out word"}, {lro_eop, lro_data}, w);
                end
                seen++;
            end
            prev_in = rx | lx;
            if (rx) begin r_act = !rin_eop; void'(r_q.pop_front()); end
            if (lx) begin l_act = !lin_eop; void'(l_q.pop_front()); l_sent++; end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, " drained"}, exp_q.size() + r_q.size() + l_q.size(), 0);
        if (exp_bubbles >= 0) check({tag, " bubbles"}, bubbles, exp_bubbles);
        zero_inputs();
    endtask

    // ---------------- main ----------------
    initial begin
        reset = 0;
        zero_inputs();
        @(negedge clk);
        do_reset("reset0");

        // Single-word packets: rs rd re | ls ld le | od || rdrdy ldrdy src osrdy odata oeop
        add_vec(1,16'h0101,1, 1,16'h0201,1, 1,  1,0,2'b01, 0,16'h0000,0);
        add_vec(1,16'h0102,1, 1,16'h0201,1, 1,  1,0,2'b01, 1,16'h0101,1);
        add_vec(1,16'h0103,1, 1,16'h0201,1, 1,  1,0,2'b01, 1,16'h0102,1);
        add_vec(1,16'h0104,1, 1,16'h0201,1, 1,  1,0,2'b01, 1,16'h0103,1);
        add_vec(1,16'h0105,1, 1,16'h0201,1, 1,  0,1,2'b10, 1,16'h0104,1);
        add_vec(1,16'h0105,1, 1,16'h0202,1, 1,  1,0,2'b01, 1,16'h0201,1);
        add_vec(1,16'h0106,1, 1,16'h0202,1, 1,  1,0,2'b01, 1,16'h0105,1);
        add_vec(1,16'h0107,1, 1,16'h0202,1, 1,  1,0,2'b01, 1,16'h0106,1);
        add_vec(1,16'h0108,1, 1,16'h0202,1, 1,  1,0,2'b01, 1,16'h0107,1);
        add_vec(1,16'h0109,1, 1,16'h0202,1, 1,  0,1,2'b10, 1,16'h0108,1);
        add_vec(1,16'h0109,1, 1,16'h0203,1, 1,  1,0,2'b01, 1,16'h0202,1);
        add_vec(0,16'h0000,0, 0,16'h0000,0, 1,  0,0,2'b00, 1,16'h0109,1);
        add_vec(0,16'h0000,0, 0,16'h0000,0, 1,  0,0,2'b00, 0,16'h0000,0);
        // Output back-pressure with a full holding stage.
        add_vec(1,16'h010A,1, 0,16'h0000,0, 0,  1,0,2'b01, 0,16'h0000,0);
        add_vec(1,16'h010B,1, 0,16'h0000,0, 0,  0,0,2'b00, 1,16'h010A,1);
        add_vec(1,16'h010B,1, 0,16'h0000,0, 1,  1,0,2'b01, 1,16'h010A,1);
        add_vec(0,16'h0000,0, 0,16'h0000,0, 1,  0,0,2'b00, 1,16'h010B,1);
        // Two-word ring packet with a source bubble; local waits.
        add_vec(1,16'h010C,0, 1,16'h0204,1, 1,  1,0,2'b01, 0,16'h0000,0);
        add_vec(0,16'h0000,0, 1,16'h0204,1, 1,  1,0,2'b01, 1,16'h010C,0);
        add_vec(1,16'h010D,1, 1,16'h0204,1, 1,  1,0,2'b01, 0,16'h0000,0);
        // Fourth ring packet since the last local: local forced in.
        add_vec(1,16'h010E,1, 1,16'h0204,1, 1,  0,1,2'b10, 1,16'h010D,1);
        add_vec(0,16'h0000,0, 0,16'h0000,0, 1,  0,0,2'b00, 1,16'h0204,1);

        for (int i = 0; i < vecs.size(); i++) begin
            rin_srdy = vecs[i].rs; rin_data = vecs[i].rd; rin_eop = vecs[i].re;
            lin_srdy = vecs[i].ls; lin_data = vecs[i].ld; lin_eop = vecs[i].le;
            lro_drdy = vecs[i].od;
            #1;
            check($sformatf("v%0d rin_drdy", i), rin_drdy, vecs[i].x_rdrdy);
            check($sformatf("v%0d lin_drdy", i), lin_drdy, vecs[i].x_ldrdy);
            check($sformatf("v%0d cur_src", i),  cur_src,  vecs[i].x_src);
            check($sformatf("v%0d lro_srdy", i), lro_srdy, vecs[i].x_osrdy);
            if (vecs[i].x_osrdy) begin
                check($sformatf("v%0d lro_data", i), lro_data, vecs[i].x_odata);
                check($sformatf("v%0d lro_eop", i),  lro_eop,  vecs[i].x_oeop);
            end
            @(posedge clk);
            @(negedge clk);
        end
        zero_inputs();

        // Ring only: three 4-word packets.
        do_reset("reset1");
        seq_setup();
        for (int i = 0; i < 12; i++) begin
            r_q.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, W'(i)});
            exp_q.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, W'(i)});
        end
        run_seq("ring_only", 60, 0, 1, 0);

        // Local 3-word packet, ring arrives mid-packet, ring wins next.
        do_reset("reset2");
        seq_setup();
        l_q = '{{1'b0, 16'h0020}, {1'b0, 16'h0021}, {1'b1, 16'h0022}, {1'b1, 16'h0023}};
        r_q = '{{1'b0, 16'h0030}, {1'b1, 16'h0031}};
        r_start = 1;
        exp_q = '{{1'b0, 16'h0020}, {1'b0, 16'h0021}, {1'b1, 16'h0022},
                  {1'b0, 16'h0030}, {1'b1, 16'h0031}, {1'b1, 16'h0023}};
        run_seq("local_then_ring", 40, 0, 0, 0);

        // Output drdy toggling during an 8-word ring packet.
        do_reset("reset3");
        seq_setup();
        for (int i = 0; i < 8; i++) begin
            r_q.push_back({(i == 7) ? 1'b1 : 1'b0, W'(i)});
            exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, W'(i)});
        end
        run_seq("drdy_toggle", 40, 1, 1, -1);

        // Local source stalls 3 cycles mid-packet while ring waits.
        do_reset("reset4");
        seq_setup();
        l_q = '{{1'b0, 16'h0050}, {1'b0, 16'h0051}, {1'b0, 16'h0052}, {1'b1, 16'h0053}};
        r_q = '{{1'b1, 16'h0060}};
        r_start = 1; l_stall_at = 2; stall_left = 3;
        exp_q = '{{1'b0, 16'h0050}, {1'b0, 16'h0051}, {1'b0, 16'h0052},
                  {1'b1, 16'h0053}, {1'b1, 16'h0060}};
        run_seq("local_stall", 40, 0, 0, 3);

        // Reset on word 2 of a 5-word local packet.
        do_reset("reset5");
        lin_srdy = 1; lin_data = 16'h0070; lin_eop = 0; lro_drdy = 1;
        #1;
        check("mid_reset first grant", cur_src, 2'b10);
        @(posedge clk);
        @(negedge clk);
        lin_data = 16'h0071;
        #1;
        check("mid_reset word0 out", lro_data, 16'h0070);
        @(posedge clk);
        @(negedge clk);
        lin_data = 16'h0072;
        reset = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        zero_inputs();
        reset = 1;
        seq_setup();
        l_q = '{{1'b0, 16'h0080}, {1'b1, 16'h0081}};
        r_q = '{{1'b1, 16'h0090}};
        r_start = 1;
        exp_q = '{{1'b0, 16'h0080}, {1'b1, 16'h0081}, {1'b1, 16'h0090}};
        run_seq("after_reset", 30, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_out_arbiter.md
RING_OUT_ARBITER -- requirements
Module: ring_out_arbiter

Interface
REQ-001 SHALL have parameter rdp_sz, default 64, ring datapath width in bits.
REQ-002 SHALL have parameter max_ring_pkts, default 4, range 1-15: consecutive ring packets allowed before a waiting local packet is forced in.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports rin_srdy input 1, rin_drdy output 1, rin_data input rdp_sz, rin_eop input 1: ring pass-through packet words from the tap.
REQ-006 SHALL have ports lin_srdy input 1, lin_drdy output 1, lin_data input rdp_sz, lin_eop input 1: local injection packet words.
REQ-007 SHALL have ports lro_srdy output 1, lro_drdy input 1, lro_data output rdp_sz, lro_eop output 1: ring output.
REQ-008 SHALL have port cur_src, output, 2, one-hot owner of the output (bit0 ring, bit1 local, 00 idle).

Function
REQ-009 A word SHALL transfer on any interface only in a cycle where srdy and drdy are both 1.
REQ-010 Output SHALL be a single registered holding stage; lro_data/lro_eop/lro_srdy come directly from flops.
REQ-011 Holding stage SHALL accept an input word when empty or being drained in the same cycle (lro_srdy & lro_drdy); full throughput one word/cycle.
REQ-012 Latency from input transfer to lro_srdy assertion SHALL be exactly 1 cycle.
REQ-013 rin_drdy/lin_drdy SHALL depend combinationally only on state, srdy inputs and holding-stage status, never on lro_data.
REQ-014 At most one of rin_drdy, lin_drdy SHALL be 1 in any cycle.
REQ-015 FSM states SHALL be one-hot: s_idle, s_ring, s_local.
REQ-016 s_idle: choose a source among pending srdy; transfer the first word in the same cycle the grant is made.
REQ-017 Grant priority: local if ring_cnt >= max_ring_pkts or last grant was ring-starved-local pending; else ring if rin_srdy; else local if lin_srdy.
REQ-018 After a local packet completes, a pending ring packet SHALL win the next arbitration (no back-to-back local when ring waits).
REQ-019 Grant SHALL hold until the eop word of that packet transfers; no interleaving of packets.
REQ-020 Single-word packet (eop on first word) SHALL go s_idle -> s_idle, grant released same cycle.
REQ-021 Multi-word: s_idle -> s_ring/s_local on first non-eop transfer; -> s_idle on eop transfer.
REQ-022 ring_cnt (4 bits) SHALL increment on each ring eop transfer, saturate at 15, clear on local eop transfer.
REQ-023 Source deasserting srdy mid-packet SHALL stall the output (bubble); grant SHALL NOT move.
REQ-024 cur_src SHALL reflect the state of the word currently being granted, 00 in s_idle with no transfer.

Reset
REQ-025 On reset low: state = s_idle, ring_cnt = 0, lro_srdy = 0, lro_eop = 0, lro_data = 0, cur_src = 00, both drdy = 0.
REQ-026 Reset mid-packet SHALL discard the holding stage and partial packet; first post-reset arbitration starts fresh.
REQ-027 Deassertion SHALL be synchronised externally; block adds no reset synchroniser.

Structure
REQ-028 State encodings, max ring_cnt width and the eop/PRW field definitions SHALL live in the shared bridge package/define file with `NUM_PORTS and `PRW_*.
REQ-029 Output holding stage SHALL be a sub-module named ring_out_hold_reg (rdp_sz+1 bits, srdy/drdy both sides).

Verification
REQ-030 Ring-only: 3 packets of 4 words, lro_drdy=1 -> 12 words out in order, 1-cycle latency, lin_drdy never 1.
REQ-031 Both always pending, max_ring_pkts=4, 1-word packets -> output pattern R R R R L R R R R L ...
REQ-032 Local 3-word packet granted, rin_srdy rises mid-packet -> ring words appear only after local eop, then ring wins next.
REQ-033 lro_drdy toggles 1/0 every cycle during 8-word ring packet -> no word lost or duplicated, data matches 0..7.
REQ-034 Reset driven low on word 2 of 5-word local packet -> all outputs zero within 0 cycles, next packet after release starts with first word.
REQ-035 lin_srdy drops for 3 cycles mid-packet with rin_srdy=1 -> output stalls 3 cycles, rin_drdy stays 0 until local eop.
